// File: rtl/oc_iic_target.sv
// oc_iic_target: I2C target with an oversampled, glitch-filtered front end and a byte register file.
// The host sets a pointer, then writes or reads bytes with auto-increment.
module oc_iic_target #(
    parameter logic [6:0] Address      = 7'h50,
    parameter int         RegCount     = 16,
    parameter int         SyncCycles   = 2,
    parameter int         FilterCycles = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        iicScl,
    output logic                        iicSclTristate,
    input  logic                        iicSda,
    output logic                        iicSdaTristate,
    output logic                        busy,
    output logic                        hostWriteValid,
    output logic [$clog2(RegCount)-1:0] hostWriteAddr,
    output logic [7:0]                  hostWriteData,
    input  logic                        localWrite,
    input  logic [$clog2(RegCount)-1:0] localAddr,
    input  logic [7:0]                  localData
);
    localparam int AW = $clog2(RegCount);
    localparam int FW = $clog2(FilterCycles + 1);

    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_e;

    // Index 0 carries SCL, index 1 carries SDA through sync and filter.
    logic [1:0]    sync_q [SyncCycles];
    logic [1:0]    filt_q, filt_p_q;
    logic [FW-1:0] fcnt_q [2];
    logic [1:0]    smp;

    assign smp = sync_q[SyncCycles-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SyncCycles; i++) sync_q[i] <= 2'b11;
            filt_q    <= 2'b11;
            filt_p_q  <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            sync_q[0] <= {iicSda, iicScl};
            for (int i = 1; i < SyncCycles; i++) sync_q[i] <= sync_q[i-1];
            filt_p_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (smp[i] != filt_q[i]) begin
                    if (fcnt_q[i] == FW'(FilterCycles - 1)) begin
                        filt_q[i] <= smp[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + 1'b1;
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;

    assign scl_rise = filt_q[0] & ~filt_p_q[0];
    assign scl_fall = ~filt_q[0] & filt_p_q[0];
    assign start_ev = filt_q[0] & ~filt_q[1] & filt_p_q[1];
    assign stop_ev  = filt_q[0] & filt_q[1] & ~filt_p_q[1];

    state_e        state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d, ack_q, ack_d, sda_rel_q, sda_rel_d, busy_q, busy_d;
    logic [AW-1:0] ptr_q, ptr_d, hw_addr_q, hw_addr_d;
    logic [7:0]    hw_data_q, hw_data_d;
    logic          hw_valid_q, hw_valid_d;
    logic [7:0]    regs_q [RegCount];
    logic [7:0]    in_byte, rd_byte;

    assign in_byte = {shift_q[6:0], filt_q[1]};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        sda_rel_d  = sda_rel_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        hw_valid_d = 1'b0;
        hw_addr_d  = hw_addr_q;
        hw_data_d  = hw_data_q;
        if (start_ev) begin
            state_d   = ADDR;
            bit_d     = 4'd0;
            sda_rel_d = 1'b1;
            busy_d    = 1'b0;
        end else if (stop_ev) begin
            state_d   = IDLE;
            sda_rel_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = in_byte;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        rw_d    = in_byte[0];
                        ack_d   = 1'b0;
                        busy_d  = in_byte[7:1] == Address;
                        state_d = busy_d ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_q) begin
                        sda_rel_d = 1'b0;
                        ack_d     = 1'b1;
                    end else if (!rw_q) begin
                        sda_rel_d = 1'b1;
                        state_d   = WR_PTR;
                        bit_d     = 4'd0;
                    end else begin
                        state_d   = RD_DATA;
                        shift_d   = rd_byte;
                        sda_rel_d = rd_byte[7];
                        bit_d     = 4'd1;
                    end
                end
                WR_PTR, WR_DATA: if (scl_rise) begin
                    shift_d = in_byte;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        state_d = WR_ACK;
                        ack_d   = 1'b0;
                        if (state_q == WR_PTR) begin
                            ptr_d = in_byte[AW-1:0];
                        end else begin
                            hw_valid_d = 1'b1;
                            hw_addr_d  = ptr_q;
                            hw_data_d  = in_byte;
                            ptr_d      = ptr_q + 1'b1;
                        end
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!ack_q) begin
                        sda_rel_d = 1'b0;
                        ack_d     = 1'b1;
                    end else begin
                        sda_rel_d = 1'b1;
                        state_d   = WR_DATA;
                        bit_d     = 4'd0;
                    end
                end
                // bit_q counts bits already presented; 0 means the next byte must be latched.
                RD_DATA: if (scl_fall) begin
                    if (bit_q == 4'd0) begin
                        shift_d   = rd_byte;
                        sda_rel_d = rd_byte[7];
                        bit_d     = 4'd1;
                    end else if (bit_q == 4'd8) begin
                        sda_rel_d = 1'b1;
                        state_d   = RD_ACK;
                        ptr_d     = ptr_q + 1'b1;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_rel_d = shift_q[6];
                        bit_d     = bit_q + 4'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    state_d = filt_q[1] ? IGNORE : RD_DATA;
                    bit_d   = 4'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_q      <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            sda_rel_q  <= 1'b1;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            hw_valid_q <= 1'b0;
            hw_addr_q  <= '0;
            hw_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            sda_rel_q  <= sda_rel_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            hw_valid_q <= hw_valid_d;
            hw_addr_q  <= hw_addr_d;
            hw_data_q  <= hw_data_d;
        end
    end

    // The host write is issued last so it wins a same-index collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RegCount; i++) regs_q[i] <= 8'h00;
        end else begin
            if (localWrite) regs_q[localAddr] <= localData;
            if (hw_valid_d) regs_q[ptr_q] <= in_byte;
        end
    end

    assign iicSclTristate = 1'b1;
    assign iicSdaTristate = sda_rel_q;
    assign busy           = busy_q;
    assign hostWriteValid = hw_valid_q;
    assign hostWriteAddr  = hw_addr_q;
    assign hostWriteData  = hw_data_q;
endmodule

// File: tb/tb_oc_iic_target.sv
// tb_oc_iic_target: bit-banged I2C host against a transaction-level register-file model.
module tb_oc_iic_target;
    localparam int Q  = 10;
    localparam int RC = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       host_scl = 1'b1, host_sda = 1'b1;
    logic       scl_tri, sda_tri, busy, hwv;
    logic [3:0] hwa;
    logic [7:0] hwd;
    logic       lw = 1'b0;
    logic [3:0] la = 4'd0;
    logic [7:0] ld = 8'h00;
    logic       sda_line;

    assign sda_line = host_sda & sda_tri;

    always #5 clock = ~clock;

    oc_iic_target dut (
        .clock(clock), .reset(reset),
        .iicScl(host_scl), .iicSclTristate(scl_tri),
        .iicSda(sda_line), .iicSdaTristate(sda_tri),
        .busy(busy),
        .hostWriteValid(hwv), .hostWriteAddr(hwa), .hostWriteData(hwd),
        .localWrite(lw), .localAddr(la), .localData(ld)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {logic [3:0] a; logic [7:0] d;} wr_t;
    logic [7:0] m_regs [RC];
    int         m_ptr;
    wr_t        exp_q [$];
    int         hw_seen = 0, hw_exp = 0;
    logic [7:0] wq [$];
    bit         lw_mode = 0;
    int         glitch_bit = -1;

    function automatic void model_reset();
        for (int i = 0; i < RC; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endfunction

    function automatic void m_write(input logic [7:0] d);
        exp_q.push_back('{a: 4'(m_ptr), d: d});
        m_regs[m_ptr] = d;
        m_ptr = (m_ptr + 1) % RC;
        hw_exp++;
    endfunction

    always @(negedge clock) begin
        wr_t e;
        if (hwv) begin
            hw_seen++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hw_addr", 32'(hwa), 32'(e.a));
                check("hw_data", 32'(hwd), 32'(e.d));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Entered with SCL low, Q clocks after its falling edge.
    task automatic send_bit(input logic b, input bit glitch, input bit lw_sync, input bit rst_here, output logic r);
        int k;
        if (rst_here) begin
            check("rst_pre_drive", 32'(sda_tri), 0);
            reset = 1'b1;
            tick(1);
            check("rst_release", 32'(sda_tri), 1);
            tick(2);
            reset = 1'b0;
            model_reset();
        end
        host_sda = b;
        tick(Q);
        host_scl = 1'b1;
        if (lw_sync) begin
            k = 0;
            while (!hwv && k < 40) begin
                tick(1);
                k++;
            end
            lw = 1'b0;
            check("lw_hw_seen", 32'(hwv), 1);
        end
        tick(Q);
        if (glitch) begin
            host_sda = 1'b0;
            tick(1);
            host_sda = b;
            tick(1);
        end
        r = sda_line;
        tick(Q);
        host_scl = 1'b0;
        tick(Q);
    endtask

    task automatic byte_wr(input logic [7:0] d, input int gbit, input bit lw_last, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit, lw_last && i == 0, 1'b0, r);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, ack);
    endtask

    task automatic byte_rd(input logic nack, input int rbit, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, 1'b0, i == rbit, r);
            d[i] = r;
        end
        send_bit(nack, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic start_c();
        if (!host_scl) begin
            host_sda = 1'b1;
            tick(Q);
            host_scl = 1'b1;
            tick(Q);
        end
        host_sda = 1'b0;
        tick(Q);
        host_scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_c();
        host_sda = 1'b0;
        tick(Q);
        host_scl = 1'b1;
        tick(Q);
        host_sda = 1'b1;
        tick(Q);
    endtask

    task automatic wr_txn(input logic [7:0] pb);
        logic a;
        bit   last;
        start_c();
        byte_wr(8'hA0, -1, 1'b0, a);
        check("wr_addr_ack", 32'(a), 0);
        check("busy_on", 32'(busy), 1);
        byte_wr(pb, -1, 1'b0, a);
        check("ptr_ack", 32'(a), 0);
        m_ptr = int'(pb) % RC;
        foreach (wq[i]) begin
            last = lw_mode && (i == wq.size() - 1);
            if (last) begin
                lw = 1'b1;
                m_regs[la] = ld;
            end
            m_write(wq[i]);
            byte_wr(wq[i], (i == 0) ? glitch_bit : -1, last, a);
            check("data_ack", 32'(a), 0);
        end
        stop_c();
        tick(Q);
        check("busy_off", 32'(busy), 0);
        check("hw_count", 32'(hw_seen), 32'(hw_exp));
    endtask

    task automatic rd_txn(input bit sp, input logic [7:0] pb, input int n);
        logic       a;
        logic [7:0] d;
        start_c();
        if (sp) begin
            byte_wr(8'hA0, -1, 1'b0, a);
            check("rd_wr_addr_ack", 32'(a), 0);
            byte_wr(pb, -1, 1'b0, a);
            check("rd_ptr_ack", 32'(a), 0);
            m_ptr = int'(pb) % RC;
            start_c();
        end
        byte_wr(8'hA1, -1, 1'b0, a);
        check("rd_addr_ack", 32'(a), 0);
        for (int i = 0; i < n; i++) begin
            byte_rd(i == n - 1, -1, d);
            check("rd_data", 32'(d), 32'(m_regs[m_ptr]));
            m_ptr = (m_ptr + 1) % RC;
        end
        check("rd_nack_rel", 32'(sda_tri), 1);
        stop_c();
        tick(Q);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic       a;
        logic [7:0] d;
        model_reset();
        tick(3);
        check("rst_sda_tri", 32'(sda_tri), 1);
        check("rst_scl_tri", 32'(scl_tri), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_hwv", 32'(hwv), 0);
        check("rst_hwa", 32'(hwa), 0);
        check("rst_hwd", 32'(hwd), 0);
        reset = 1'b0;
        tick(4);
        wq = '{8'h11, 8'h22};
        wr_txn(8'h03);
        rd_txn(1'b1, 8'h03, 2);
        rd_txn(1'b0, 8'h00, 1);
        start_c();
        byte_wr(8'hA2, -1, 1'b0, a);
        check("nomatch_ack", 32'(a), 1);
        check("nomatch_busy", 32'(busy), 0);
        byte_wr(8'h05, -1, 1'b0, a);
        check("nomatch_b1", 32'(a), 1);
        byte_wr(8'h33, -1, 1'b0, a);
        check("nomatch_b2", 32'(a), 1);
        stop_c();
        tick(Q);
        check("nomatch_hw", 32'(hw_seen), 32'(hw_exp));
        wq = '{8'hAA, 8'hBB};
        wr_txn(8'h0F);
        rd_txn(1'b1, 8'h0F, 2);
        rd_txn(1'b1, 8'hF3, 1);
        lw_mode = 1;
        la = 4'd5;
        ld = 8'h77;
        wq = '{8'h99};
        wr_txn(8'h05);
        la = 4'd6;
        wq = '{8'h44};
        wr_txn(8'h05);
        lw_mode = 0;
        rd_txn(1'b1, 8'h04, 3);
        start_c();
        byte_wr(8'hA0, -1, 1'b0, a);
        byte_wr(8'h04, -1, 1'b0, a);
        start_c();
        byte_wr(8'hA1, -1, 1'b0, a);
        byte_rd(1'b1, 4, d);
        stop_c();
        tick(Q);
        rd_txn(1'b0, 8'h00, 2);
        glitch_bit = 7;
        wq = '{8'hC3, 8'h5A};
        wr_txn(8'h07);
        glitch_bit = -1;
        rd_txn(1'b1, 8'h07, 2);
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                la = 4'($urandom);
                ld = 8'($urandom);
                lw = 1'b1;
                tick(1);
                lw = 1'b0;
                m_regs[la] = ld;
            end
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                repeat ($urandom_range(1, 3)) wq.push_back(8'($urandom));
                wr_txn(8'($urandom));
            end else begin
                rd_txn(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 3)));
            end
        end
        rd_txn(1'b1, 8'h00, RC);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
